// File: rtl/fifo_rr_scheduler.sv
// Round-robin drain scheduler: grants one non-empty show-ahead FIFO at a time,
// pops up to MAXBURST words into a single registered valid/ready output stage.
module fifo_rr_scheduler #(
  parameter int WIDTH    = 32,
  parameter int NUM      = 4,
  parameter int MAXBURST = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM-1:0]          fifo_empty,
  input  logic [NUM*WIDTH-1:0]    fifo_dataout,
  output logic [NUM-1:0]          fifo_read,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NUM)-1:0]  out_source,
  output logic                    out_last
);

  localparam int GW = $clog2(NUM);
  localparam int CW = $clog2(MAXBURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t           r_state, w_state_nxt;
  logic [GW-1:0]    r_grant, w_grant_nxt;
  logic [GW-1:0]    r_ptr, w_ptr_nxt;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic [WIDTH-1:0] r_out_data, w_data_nxt;
  logic [GW-1:0]    r_out_source, w_src_nxt;
  logic             r_out_valid, w_valid_nxt;
  logic             r_out_last, w_last_nxt;

  logic             w_any;
  logic [GW-1:0]    w_first;
  logic             w_gnt_empty;
  logic [WIDTH-1:0] w_head;
  logic [GW-1:0]    w_gnt_inc;
  logic             w_can_pop;
  logic             w_pop;
  logic             w_last_word;

  assign w_any       = |(~fifo_empty);
  assign w_can_pop   = !r_out_valid || out_ready;
  assign w_gnt_inc   = (r_grant == GW'(NUM - 1)) ? '0 : r_grant + 1'b1;
  assign w_last_word = (r_count + 1'b1) == CW'(MAXBURST);
  assign w_pop       = !reset && enable && (r_state == S_BURST) && !w_gnt_empty && w_can_pop;

  // Nearest non-empty source at or after ptr, measured as rotational distance.
  always_comb begin
    int best_d;
    int d;
    best_d  = NUM;
    d       = 0;
    w_first = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!fifo_empty[i]) begin
        d = (i >= int'(r_ptr)) ? i - int'(r_ptr) : i + NUM - int'(r_ptr);
        if (d < best_d) begin
          best_d  = d;
          w_first = GW'(i);
        end
      end
    end
  end

  always_comb begin
    w_gnt_empty = 1'b1;
    w_head      = '0;
    fifo_read   = '0;
    for (int i = 0; i < NUM; i++) begin
      if (GW'(i) == r_grant) begin
        w_gnt_empty  = fifo_empty[i];
        w_head       = fifo_dataout[i*WIDTH +: WIDTH];
        fifo_read[i] = w_pop;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_data_nxt  = r_out_data;
    w_src_nxt   = r_out_source;
    w_last_nxt  = r_out_last;
    w_valid_nxt = r_out_valid && !out_ready;
    case (r_state)
      S_IDLE: begin
        if (enable && w_any) begin
          w_grant_nxt = w_first;
          w_count_nxt = '0;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (!enable || w_gnt_empty) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = w_gnt_inc;
        end else if (w_can_pop) begin
          w_data_nxt  = w_head;
          w_src_nxt   = r_grant;
          w_valid_nxt = 1'b1;
          w_last_nxt  = w_last_word;
          w_count_nxt = r_count + 1'b1;
          if (w_last_word) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = w_gnt_inc;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_ptr        <= '0;
      r_count      <= '0;
      r_out_data   <= '0;
      r_out_source <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_ptr        <= w_ptr_nxt;
      r_count      <= w_count_nxt;
      r_out_data   <= w_data_nxt;
      r_out_source <= w_src_nxt;
      r_out_valid  <= w_valid_nxt;
      r_out_last   <= w_last_nxt;
    end
  end

  assign out_data   = r_out_data;
  assign out_source = r_out_source;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Directed bench for fifo_rr_scheduler with NUM=3 behavioural show-ahead FIFOs.
module tb_fifo_rr_scheduler;

  localparam int WIDTH    = 16;
  localparam int NUM      = 3;
  localparam int MAXBURST = 8;
  localparam int GW       = $clog2(NUM);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   enable;
  logic [NUM-1:0]         fifo_empty;
  logic [NUM*WIDTH-1:0]   fifo_dataout;
  logic [NUM-1:0]         fifo_read;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [GW-1:0]          out_source;
  logic                   out_last;

  fifo_rr_scheduler #(.WIDTH(WIDTH), .NUM(NUM), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout), .fifo_read(fifo_read),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_source(out_source), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Show-ahead source FIFOs: pop visible the cycle after fifo_read.
  logic [WIDTH-1:0] mem [NUM][64];
  int rd [NUM];
  int wr [NUM];

  always @(posedge clk)
    for (int i = 0; i < NUM; i++)
      if (fifo_read[i]) rd[i] <= rd[i] + 1;

  always_comb begin
    fifo_empty   = '0;
    fifo_dataout = '0;
    for (int i = 0; i < NUM; i++) begin
      fifo_empty[i]                    = (rd[i] == wr[i]);
      fifo_dataout[i*WIDTH +: WIDTH]   = mem[i][6'(rd[i])];
    end
  end

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] lg [$];
  int lc [$];
  int n_pop, first_rd, first_ov;
  bit ptr_bad, onehot_bad;

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      lg.push_back({7'b0, out_last, 8'(out_source), out_data});
      lc.push_back(cyc);
    end
    if (fifo_read != '0) begin
      n_pop++;
      if (first_rd < 0) first_rd = cyc;
    end
    if ($countones(fifo_read) > 1) onehot_bad = 1'b1;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (int'(dut.r_ptr) >= NUM) ptr_bad = 1'b1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [WIDTH-1:0] dat(int s, int k);
    return WIDTH'(s * 256 + (k & 255));
  endfunction

  function automatic logic [31:0] ex(int s, int k, bit last);
    return {7'b0, last, 8'(s), dat(s, k)};
  endfunction

  function automatic logic [31:0] lgat(int i);
    return (i < lg.size()) ? lg[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic exp_word(input int i, input int s, input int k, input bit last);
    check($sformatf("word%0d", i), lgat(i), ex(s, k, last));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      mem[s][6'(wr[s])] = dat(s, wr[s]);
      wr[s]++;
    end
  endtask

  task automatic clear_log();
    lg.delete();
    lc.delete();
    n_pop    = 0;
    first_rd = -1;
    first_ov = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check("valid_seen", 32'(out_valid), 1);
  endtask

  int L, b0, b1, b2, idx;

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < NUM; i++) wr[i] = 0;
    clear_log();
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_source", 32'(out_source), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_read", 32'(fifo_read), 0);
    check("rst_ptr", 32'(dut.r_ptr), 0);

    // Single source, three words
    tick();
    enable = 1'b1;
    clear_log();
    L = cyc; b0 = wr[0];
    load(0, 3);
    repeat (12) tick();
    check("t1_pops", 32'(n_pop), 3);
    check("t1_nwords", 32'(lg.size()), 3);
    for (int k = 0; k < 3; k++) exp_word(k, 0, b0 + k, 1'b0);
    check("t1_read_lat", 32'(first_rd - L), 1);
    check("t1_valid_lat", 32'(first_ov - L), 2);
    check("t1_b2b", 32'(lc.size() == 3 ? lc[2] - lc[0] : -1), 2);
    check("t1_ptr", 32'(dut.r_ptr), 1);

    // Fairness across sources 0 and 1
    do_reset();
    clear_log();
    b0 = wr[0]; b1 = wr[1];
    load(0, 10); load(1, 10);
    repeat (40) tick();
    check("t2_nwords", 32'(lg.size()), 20);
    idx = 0;
    for (int k = 0; k < 8; k++) begin exp_word(idx, 0, b0 + k, k == 7); idx++; end
    for (int k = 0; k < 8; k++) begin exp_word(idx, 1, b1 + k, k == 7); idx++; end
    for (int k = 8; k < 10; k++) begin exp_word(idx, 0, b0 + k, 1'b0); idx++; end
    for (int k = 8; k < 10; k++) begin exp_word(idx, 1, b1 + k, 1'b0); idx++; end
    check("t2_bubble", 32'(lc.size() > 8 ? lc[8] - lc[7] : -1), 2);
    check("t2_nobubble", 32'(lc.size() > 8 ? lc[7] - lc[6] : -1), 1);

    // Backpressure for three cycles after the first word
    do_reset();
    clear_log();
    b0 = wr[0];
    load(0, 5);
    wait_valid();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t3_hold%0d", i), 32'(out_data), 32'(dat(0, b0 + 1)));
      check($sformatf("t3_noread%0d", i), 32'(fifo_read), 0);
    end
    tick();
    out_ready = 1'b1;
    repeat (15) tick();
    check("t3_nwords", 32'(lg.size()), 5);
    check("t3_pops", 32'(n_pop), 5);
    for (int k = 0; k < 5; k++) exp_word(k, 0, b0 + k, 1'b0);

    // Pointer wrap with NUM=3 starting at ptr=2
    do_reset();
    load(1, 1);
    repeat (10) tick();
    check("t4_ptr2", 32'(dut.r_ptr), 2);
    clear_log();
    ptr_bad = 1'b0;
    b0 = wr[0]; b2 = wr[2];
    load(0, 10); load(2, 10);
    repeat (40) tick();
    check("t4_nwords", 32'(lg.size()), 20);
    idx = 0;
    for (int k = 0; k < 8; k++) begin exp_word(idx, 2, b2 + k, k == 7); idx++; end
    for (int k = 0; k < 8; k++) begin exp_word(idx, 0, b0 + k, k == 7); idx++; end
    for (int k = 8; k < 10; k++) begin exp_word(idx, 2, b2 + k, 1'b0); idx++; end
    for (int k = 8; k < 10; k++) begin exp_word(idx, 0, b0 + k, 1'b0); idx++; end
    check("t4_ptr_range", 32'(ptr_bad), 0);

    // Enable dropped on the fourth pop of a burst
    do_reset();
    clear_log();
    b0 = wr[0]; b1 = wr[1];
    load(0, 6); load(1, 2);
    for (int i = 0; i < 50 && n_pop != 3; i++) tick();
    enable = 1'b0;
    @(negedge clk);
    check("t5_nopop", 32'(fifo_read), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check($sformatf("t5_idle_read%0d", i), 32'(fifo_read), 0);
    end
    check("t5_pops", 32'(n_pop), 3);
    check("t5_ptr", 32'(dut.r_ptr), 1);
    tick();
    enable = 1'b1;
    repeat (20) tick();
    check("t5_nwords", 32'(lg.size()), 8);
    idx = 0;
    for (int k = 0; k < 3; k++) begin exp_word(idx, 0, b0 + k, 1'b0); idx++; end
    for (int k = 0; k < 2; k++) begin exp_word(idx, 1, b1 + k, 1'b0); idx++; end
    for (int k = 3; k < 6; k++) begin exp_word(idx, 0, b0 + k, 1'b0); idx++; end

    // Reset mid-burst with a word held in the output register
    do_reset();
    b1 = wr[1];
    load(1, 6);
    wait_valid();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_read_in_rst", 32'(fifo_read), 0);
    tick();
    reset = 1'b0;
    clear_log();
    b0 = wr[0];
    load(0, 1);
    @(negedge clk);
    check("t6_valid", 32'(out_valid), 0);
    check("t6_data", 32'(out_data), 0);
    check("t6_source", 32'(out_source), 0);
    check("t6_last", 32'(out_last), 0);
    check("t6_ptr", 32'(dut.r_ptr), 0);
    repeat (25) tick();
    check("t6_nwords", 32'(lg.size()), 5);
    exp_word(0, 0, b0, 1'b0);
    for (int k = 2; k < 6; k++) exp_word(k - 1, 1, b1 + k, 1'b0);

    check("onehot_read", 32'(onehot_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
# fifo_rr_scheduler

Round-robin drain scheduler that shares one downstream consumer between NUM show-ahead source FIFOs. It grants one non-empty FIFO at a time and pops up to MAXBURST words from it. Each word goes into a single registered valid/ready output stage, tagged with its source index. The block sits between a bank of `fifo` instances (first-word-fallthrough, registered empty) and a single egress path, e.g. a DMA or serializer.

## Interface
Parameters:
- WIDTH, 32, data word width
- NUM, 4, number of source FIFOs (≥2, any integer, need not be a power of two)
- MAXBURST, 8, maximum words popped per grant (≥1)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- enable  input  1  permits new grants and pops
- fifo_empty  input  NUM  per-source empty flag (registered in source)
- fifo_dataout  input  NUM*WIDTH  per-source head word, slice i = bits [i*WIDTH +: WIDTH]
- fifo_read  output  NUM  per-source pop strobe, one-hot or zero
- out_data  output  WIDTH  output word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts word when out_valid && out_ready
- out_source  output  $clog2(NUM)  index of source of out_data
- out_last  output  1  word is the MAXBURST-th of its grant

## Operation
- Source contract: when fifo_empty[i]=0, the head word is on slice i. Pulsing fifo_read[i] pops it. The next head and the updated empty are visible the following cycle.
- State register: IDLE, BURST. Additional registers:
  - grant: $clog2(NUM) bits
  - ptr: round-robin start
  - count: $clog2(MAXBURST+1) bits
- IDLE:
  - If enable=1 and any fifo_empty bit is 0, set grant to the first non-empty index searching ptr, ptr+1, … wrapping mod NUM.
  - Clear count and go to BURST.
  - Otherwise stay in IDLE.
- can_pop = !out_valid || out_ready.
- BURST, if enable=1, fifo_empty[grant]=0 and can_pop:
  - fifo_read[grant]=1 combinationally.
  - Load out_data ← slice grant, out_source ← grant, out_valid ← 1, out_last ← (count+1 == MAXBURST).
  - count ← count+1.
  - If count+1 == MAXBURST: go to IDLE, ptr ← (grant+1) mod NUM.
- BURST, if fifo_empty[grant]=1 or enable=0: no pop, go to IDLE, ptr ← (grant+1) mod NUM. out_last is not asserted retroactively.
- BURST, if fifo_empty[grant]=0, enable=1, can_pop=0 (stall): hold state, count and output.
- Output stage: if out_valid && out_ready and no new pop this cycle, out_valid ← 0. All other output regs hold.
- fifo_read is forced to zero in these cases:
  - in IDLE
  - while reset=1
  - for every index ≠ grant

## Timing
- Reset values:
  - state IDLE, ptr 0, grant 0, count 0
  - out_valid 0, out_data 0, out_source 0, out_last 0
  - fifo_read 0 (combinational, gated by reset)
- Reset mid-burst: the cycle after reset, the block is in IDLE with out_valid=0. A word held in the output register is discarded. No pop occurs during reset.
- Arbitration latency:
  - IDLE cycle N sees a non-empty source.
  - BURST at N+1, with the first fifo_read at N+1.
  - out_valid=1 at N+2.
- Throughput: 1 word/cycle within a burst while out_ready=1. Each grant change costs exactly one IDLE cycle.
- Fairness: at most MAXBURST words per grant. A continuously non-empty source waits at most (NUM-1)·(MAXBURST+1) cycles of unstalled output before its next grant.
- enable deassertion takes effect the same cycle: no pop, BURST→IDLE.
- The output word is never overwritten while out_valid && !out_ready.

## Test plan
- Single source: FIFO 0 holds A,B,C, out_ready=1, MAXBURST=8.
  - Response: fifo_read[0] high 3 cycles, out_data A,B,C on consecutive cycles, out_source=0, out_last never set.
  - Then one cycle with fifo_empty[0]=1 in BURST, then IDLE, ptr=1.
- Fairness: sources 0 and 1 each hold 10 words, MAXBURST=8, out_ready=1.
  - Response: 8 from source 0 (out_last on the 8th), 8 from source 1, 2 from 0, 2 from 1.
  - One IDLE bubble between grants.
- Backpressure: hold out_ready=0 for 3 cycles after the first word.
  - Response: out_data stable and fifo_read=0 during the stall.
  - Resumes with no lost or duplicated words; total count matches.
- Wrap with NUM=3: ptr=2, sources 0 and 2 non-empty.
  - Response: grant order 2, 0, 2, …; ptr wraps 2→0 without reaching the value 3.
- enable drop: deassert enable on the 4th word of a burst.
  - Response: no pop that cycle, state IDLE next cycle, no grants while enable=0.
  - Re-enable: grant goes to the next source after the interrupted one.
- Reset mid-burst: assert reset for 1 cycle while out_valid=1.
  - Response: all outputs at reset values next cycle, fifo_read=0 during reset.
  - Arbitration restarts from source 0.
